// File: rtl/apb_master_if.sv
// apb_master_if: upstream request/response handshake plus APB initiator bus, with master (bridge) and slave (environment) views.
interface apb_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_we;
  logic [3:0]            req_stb;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pdata;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [3:0]            pstb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  perr;
  modport master (
    input  req_valid, req_addr, req_wdata, req_we, req_stb, prdata, pready, perr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pdata, psel, penable, pwrite, pstb
  );
  modport slave (
    output req_valid, req_addr, req_wdata, req_we, req_stb, prdata, pready, perr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pdata, psel, penable, pwrite, pstb
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: bridges one valid/ready request at a time onto an APB SETUP/ACCESS transfer and returns a one-cycle response.
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic          pclk,
  input logic          presetn,
  apb_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t                r_state, w_next;
  logic                  r_req_ready;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pdata;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [3:0]            r_pstb;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_tmo;
  assign w_accept = r_state == IDLE && bus.req_valid;
  assign w_done   = r_state == ACCESS && bus.pready;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  // Counts consecutive wait cycles; a ready in the firing cycle takes priority.
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) r_cnt <= '0;
    else if (r_state == SETUP) r_cnt <= '0;
    else if (r_state == ACCESS && !bus.pready) r_cnt <= r_cnt + 1'b1;
  assign w_tmo = r_state == ACCESS && !bus.pready && r_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = |TIMEOUT_CYCLES;
  assign w_tmo = 1'b0;
`endif
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.req_valid ? SETUP : IDLE;
      SETUP:   w_next = ACCESS;
      ACCESS:  w_next = (w_done || w_tmo) ? IDLE : ACCESS;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      r_req_ready <= 1'b1;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pdata     <= '0;
      r_pwrite    <= 1'b0;
      r_pstb      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_req_ready <= w_next == IDLE;
      r_psel      <= w_next != IDLE;
      r_penable   <= w_next == ACCESS;
      r_rsp_valid <= w_done || w_tmo;
      if (w_accept) begin
        r_paddr  <= bus.req_addr;
        r_pdata  <= bus.req_wdata;
        r_pwrite <= bus.req_we;
        r_pstb   <= bus.req_we ? bus.req_stb : 4'b0000;
      end
      if (w_done) begin
        r_rsp_err <= bus.perr;
        if (!r_pwrite) r_rsp_rdata <= bus.prdata;
      end else if (w_tmo) begin
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= '0;
      end
    end
  assign bus.req_ready = r_req_ready;
  assign bus.paddr     = r_paddr;
  assign bus.pdata     = r_pdata;
  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.pstb      = r_pstb;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed table of APB transfers with hand-computed responses, plus back-to-back and mid-transfer reset sequences.
module tb_apb_master;
  logic pclk = 1'b0;
  logic presetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;
  apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk),
    .presetn(presetn),
    .bus(bus.master)
  );
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  stb;
    int          waits;
    logic        perr;
    int          lat;
    logic [3:0]  exp_pstb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[$];
  function automatic logic [7:0] sram_byte(input logic [31:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction
  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return {sram_byte(a + 3), sram_byte(a + 2), sram_byte(a + 1), sram_byte(a)};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Called at the negedge of the accept cycle; returns at the negedge of the response cycle.
  task automatic xfer(input vec_t v, input bit hold, output int acc);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_we    = v.we;
    bus.req_stb   = v.stb;
    acc = cyc;
    @(negedge pclk);
    if (!hold) begin
      bus.req_valid = 1'b0;
      bus.req_addr  = ~v.addr;
      bus.req_wdata = ~v.wdata;
      bus.req_we    = ~v.we;
      bus.req_stb   = ~v.stb;
    end
    bus.pready = 1'b1;
    bus.perr   = 1'b1;
    bus.prdata = 32'hBAD0BAD0;
    chk("setup_psel", bus.psel, 1);
    chk("setup_penable", bus.penable, 0);
    chk("setup_req_ready", bus.req_ready, 0);
    chk("setup_paddr", bus.paddr, v.addr);
    chk("setup_pdata", bus.pdata, v.wdata);
    chk("setup_pwrite", bus.pwrite, v.we);
    chk("setup_pstb", bus.pstb, v.exp_pstb);
    for (int k = 0; k < v.lat - 2; k++) begin
      @(negedge pclk);
      bus.pready = k == v.waits;
      bus.perr   = k == v.waits ? v.perr : ~v.perr;
      bus.prdata = k == v.waits ? sram_word(v.addr) : 32'hBAD0BAD0;
      chk("access_psel_penable", {bus.psel, bus.penable}, 2'b11);
      chk("access_stable", {bus.paddr ^ v.addr, bus.pdata ^ v.wdata}, '0);
      chk("access_ctrl", {bus.pwrite, bus.pstb, bus.rsp_valid}, {v.we, v.exp_pstb, 1'b0});
    end
    @(negedge pclk);
    bus.pready = 1'b0;
    bus.perr   = 1'b0;
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_err", bus.rsp_err, v.exp_err);
    chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    chk("rsp_psel_low", bus.psel, 0);
    chk("rsp_latency", cyc - acc, v.lat);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int a0, a1, a2;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_we    = 1'b0;
    bus.req_stb   = '0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.perr      = 1'b0;
    //           we    addr           wdata          stb     w   perr lat pstb   rdata          err
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 3, 4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h1111_2222, 4'hF, 1, 1'b0, 4, 4'h0, 32'hB3B0B1B6, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'h12345678, 4'h5, 5, 1'b1, 8, 4'h5, 32'hB3B0B1B6, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0100, 32'h0000_0000, 4'h0, 0, 1'b1, 3, 4'h0, 32'hA6A7A4A5, 1'b1});
    vecs.push_back('{1'b0, 32'h7FFF_FFFD, 32'hFFFF_FFFF, 4'hA, 2, 1'b0, 5, 4'h0, 32'hA55A5B58, 1'b0});
    vecs.push_back('{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 0, 1'b0, 3, 4'h0, 32'hA55A5B58, 1'b0});
`ifdef APB_MASTER_TIMEOUT_EN
    vecs.push_back('{1'b0, 32'h0000_0200, 32'h0000_0000, 4'h0, 99, 1'b0, 18, 4'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h0000_0000, 4'h0, 15, 1'b1, 18, 4'h0, 32'hB3B0B1B6, 1'b1});
`else
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h0000_0000, 4'h0, 20, 1'b0, 23, 4'h0, 32'hB3B0B1B6, 1'b0});
`endif
    #12;
    chk("rst_bus", {bus.psel, bus.penable, bus.pwrite, bus.pstb, bus.rsp_valid, bus.rsp_err}, '0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pdata", bus.pdata, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("rst_req_ready", bus.req_ready, 1);
    foreach (vecs[i]) begin
      xfer(vecs[i], 1'b0, a0);
      @(negedge pclk);
      chk("rsp_single_pulse", bus.rsp_valid, 0);
    end
    xfer('{1'b1, 32'h0000_0030, 32'hCAFEF00D, 4'hF, 0, 1'b0, 3, 4'hF, 32'hB3B0B1B6, 1'b0}, 1'b1, a0);
    xfer('{1'b0, 32'h0000_0100, 32'h0000_0000, 4'h0, 0, 1'b0, 3, 4'h0, 32'hA6A7A4A5, 1'b0}, 1'b1, a1);
    xfer('{1'b1, 32'h0000_0034, 32'h0BADCAFE, 4'hC, 0, 1'b1, 3, 4'hC, 32'hA6A7A4A5, 1'b1}, 1'b0, a2);
    chk("b2b_spacing_1", a1 - a0, 3);
    chk("b2b_spacing_2", a2 - a1, 3);
    @(negedge pclk);
    chk("b2b_single_pulse", bus.rsp_valid, 0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0040;
    bus.req_wdata = 32'h5555_AAAA;
    bus.req_we    = 1'b1;
    bus.req_stb   = 4'hF;
    @(negedge pclk);
    bus.req_valid = 1'b0;
    @(negedge pclk);
    chk("abort_in_access", {bus.psel, bus.penable}, 2'b11);
    bus.pready = 1'b1;
    #2 presetn = 1'b0;
    #1;
    chk("abort_psel_drop", {bus.psel, bus.penable, bus.rsp_valid}, 3'b000);
    chk("abort_paddr_clr", bus.paddr, 0);
    @(negedge pclk);
    presetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      chk("abort_no_rsp", {bus.rsp_valid, bus.psel}, 2'b00);
    end
    bus.pready = 1'b0;
    xfer('{1'b1, 32'h0000_0044, 32'h0000_AA55, 4'h3, 0, 1'b0, 3, 4'h3, 32'h0000_0000, 1'b0}, 1'b0, a0);
    @(negedge pclk);
    chk("post_abort_pulse", bus.rsp_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
